mem_stage_sram_ctrl: RTL and testbench

- Memory-stage controller that consumes the EXE/MEM pipeline register outputs (alu_result as address, val_rm as store data, mem_r_en, mem_w_en).
- Performs 32-bit loads and stores against an external 16-bit-wide SRAM as two half-word accesses.
- Returns load data to the MEM/WB register.
- Asserts freeze to stall every upstream pipeline register while an access is in flight.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/sram_wait_counter.sv | 37 +++
 rtl/mem_stage_sram_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-stage SRAM controller and its helpers.
package mem_pkg;

    localparam int unsigned DATA_W              = 32;
    localparam int unsigned HALF_W              = 16;
    localparam int unsigned DEFAULT_SRAM_AW     = 18;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
    localparam int unsigned WAIT_CNT_W          = 4;
    localparam logic [DATA_W-1:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [2:0] {
        StIdle,
        StWrLo,
        StWrHi,
        StRdLo,
        StRdHi,
        StDone
    } mem_state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: clears to 0, counts up while enabled, flags the last cycle of a phase.
module sram_wait_counter
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    output logic [WAIT_CNT_W-1:0] count,
    output logic                  tc
);

    logic [WAIT_CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == WAIT_CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: 32-bit loads/stores as two half-word accesses on a 16-bit async SRAM,
// freezing the upstream pipeline while an access is in flight.
module mem_stage_sram_ctrl
    import mem_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned       WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned       SRAM_AW     = DEFAULT_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [DATA_W-1:0]  val_rm,
    output logic [DATA_W-1:0]  rd_data,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [HALF_W-1:0]  sram_dq,
    output logic               sram_we_n
);

    mem_state_e state_q, state_d;

    logic [DATA_W-1:0]     offset;
    logic [SRAM_AW-2:0]    word_idx;
    logic [SRAM_AW-1:0]    addr_lo, addr_hi;
    logic                  unused_offset_bits;
    logic                  in_phase, cnt_clear, tc;
    logic [WAIT_CNT_W-1:0] wait_count;
    logic                  dq_drive;
    logic [HALF_W-1:0]     dq_out;
    logic [DATA_W-1:0]     rd_data_q;

    // Out-of-range addresses wrap silently; only the SRAM-sized word index is kept.
    assign offset             = alu_result - BASE_ADDR;
    assign word_idx           = offset[SRAM_AW:2];
    assign unused_offset_bits = ^{offset[DATA_W-1:SRAM_AW+1], offset[1:0], wait_count};
    assign addr_lo            = {word_idx, 1'b0};
    assign addr_hi            = {word_idx, 1'b1};

    assign cnt_clear = ~in_phase | tc;

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk  (clk),
        .rst  (rst),
        .clear(cnt_clear),
        .en   (in_phase),
        .count(wait_count),
        .tc   (tc)
    );

    always_comb begin
        state_d   = state_q;
        in_phase  = 1'b0;
        sram_addr = '0;
        sram_we_n = 1'b1;
        dq_drive  = 1'b0;
        dq_out    = '0;
        unique case (state_q)
            StIdle: begin
                if (mem_w_en) begin
                    state_d = StWrLo;
                end else if (mem_r_en) begin
                    state_d = StRdLo;
                end
            end
            StWrLo: begin
                in_phase  = 1'b1;
                sram_addr = addr_lo;
                sram_we_n = 1'b0;
                dq_drive  = 1'b1;
                dq_out    = val_rm[HALF_W-1:0];
                if (tc) state_d = StWrHi;
            end
            StWrHi: begin
                in_phase  = 1'b1;
                sram_addr = addr_hi;
                sram_we_n = 1'b0;
                dq_drive  = 1'b1;
                dq_out    = val_rm[DATA_W-1:HALF_W];
                if (tc) state_d = StDone;
            end
            StRdLo: begin
                in_phase  = 1'b1;
                sram_addr = addr_lo;
                if (tc) state_d = StRdHi;
            end
            StRdHi: begin
                in_phase  = 1'b1;
                sram_addr = addr_hi;
                if (tc) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Each half is sampled on the last cycle of its phase, after the full wait time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (tc && state_q == StRdLo) begin
            rd_data_q[HALF_W-1:0] <= sram_dq;
        end else if (tc && state_q == StRdHi) begin
            rd_data_q[DATA_W-1:HALF_W] <= sram_dq;
        end
    end

    assign sram_dq = dq_drive ? dq_out : {HALF_W{1'bz}};
    assign rd_data = rd_data_q;
    assign ready   = (state_q == StDone) || (state_q == StIdle && !(mem_r_en || mem_w_en));
    assign freeze  = (mem_r_en | mem_w_en) & ~ready;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small async SRAM model on the 16-bit bus.
module tb_mem_stage_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] alu_result, val_rm;
    logic [31:0] rd_data;
    logic        ready, freeze;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n;

    logic [15:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_addr;
    logic [15:0] pl_data;
    logic        unused_tb;

    int n_vec = 0;
    int n_err = 0;

    mem_stage_sram_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .alu_result(alu_result),
        .val_rm    (val_rm),
        .rd_data   (rd_data),
        .ready     (ready),
        .freeze    (freeze),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_we_n (sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM drives the bus whenever it is not being written.
    assign sram_dq   = sram_we_n ? mem[sram_addr[5:0]] : 16'hzzzz;
    assign unused_tb = ^sram_addr[17:6];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!sram_we_n) begin
            mem[sram_addr[5:0]] <= sram_dq;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic go_idle(input string tag);
        @(negedge clk);
        mem_w_en = 1'b0;
        mem_r_en = 1'b0;
        #1;
        check_eq({tag, "/idle_ready"}, {31'b0, ready}, 32'd1);
        check_eq({tag, "/idle_freeze"}, {31'b0, freeze}, 32'd0);
        check_eq({tag, "/idle_we_n"}, {31'b0, sram_we_n}, 32'd1);
        check_eq({tag, "/idle_addr"}, {14'b0, sram_addr}, 32'd0);
    endtask

    // Drives a request and checks handshake and SRAM pins in cycles 0..5; returns in DONE.
    task automatic do_access(input string tag, input logic w, input logic r,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic [17:0] lo);
        logic [17:0] exp_addr;
        logic        exp_we_n;
        @(negedge clk);
        mem_w_en   = w;
        mem_r_en   = r;
        alu_result = addr;
        val_rm     = data;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_addr = (c == 1 || c == 2) ? lo : (c == 3 || c == 4) ? (lo | 18'd1) : 18'd0;
            exp_we_n = (w && c >= 1 && c <= 4) ? 1'b0 : 1'b1;
            check_eq($sformatf("%s/c%0d_freeze", tag, c), {31'b0, freeze}, {31'b0, c < 5});
            check_eq($sformatf("%s/c%0d_ready", tag, c), {31'b0, ready}, {31'b0, c == 5});
            check_eq($sformatf("%s/c%0d_addr", tag, c), {14'b0, sram_addr}, {14'b0, exp_addr});
            check_eq($sformatf("%s/c%0d_we_n", tag, c), {31'b0, sram_we_n}, {31'b0, exp_we_n});
        end
    endtask

    initial begin
        rst        = 1'b1;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        alu_result = 32'd0;
        val_rm     = 32'd0;
        pl_en      = 1'b0;
        pl_addr    = 6'd0;
        pl_data    = 16'd0;

        for (int i = 0; i < 64; i++) preload(6'(i), 16'h0000);
        preload(6'd2, 16'h5678);
        preload(6'd3, 16'h1234);
        preload(6'd0, 16'h0F0F);

        #1;
        check_eq("reset/rd_data", rd_data, 32'd0);
        check_eq("reset/ready", {31'b0, ready}, 32'd1);
        check_eq("reset/freeze", {31'b0, freeze}, 32'd0);
        check_eq("reset/we_n", {31'b0, sram_we_n}, 32'd1);
        check_eq("reset/addr", {14'b0, sram_addr}, 32'd0);
        check_eq("reset/dq_released", {16'b0, sram_dq}, 32'h0000_0F0F);

        @(negedge clk);
        rst = 1'b0;
        go_idle("post_reset");

        do_access("store", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0);
        check_eq("store/mem0", {16'b0, mem[0]}, 32'h0000_BEEF);
        check_eq("store/mem1", {16'b0, mem[1]}, 32'h0000_DEAD);
        check_eq("store/rd_data", rd_data, 32'd0);
        go_idle("store");

        do_access("load", 1'b0, 1'b1, 32'd1028, 32'h0, 18'd2);
        check_eq("load/rd_data", rd_data, 32'h1234_5678);
        go_idle("load");

        do_access("b2b_st", 1'b1, 1'b0, 32'd1040, 32'h0000_0042, 18'd8);
        do_access("b2b_ld", 1'b0, 1'b1, 32'd1040, 32'h0, 18'd8);
        check_eq("b2b/rd_data", rd_data, 32'h0000_0042);
        check_eq("b2b/mem8", {16'b0, mem[8]}, 32'h0000_0042);
        check_eq("b2b/mem9", {16'b0, mem[9]}, 32'h0000_0000);
        go_idle("b2b");

        do_access("both", 1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 18'd4);
        check_eq("both/mem4", {16'b0, mem[4]}, 32'h0000_A5A5);
        check_eq("both/mem5", {16'b0, mem[5]}, 32'h0000_A5A5);
        check_eq("both/rd_data", rd_data, 32'h0000_0042);
        go_idle("both");

        // Abort a load in its high phase; reset must take effect between clock edges.
        @(negedge clk);
        mem_r_en   = 1'b1;
        alu_result = 32'd1028;
        repeat (3) @(negedge clk);
        #1;
        check_eq("abort/rd_hi_addr", {14'b0, sram_addr}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort/rd_data", rd_data, 32'd0);
        check_eq("abort/we_n", {31'b0, sram_we_n}, 32'd1);
        check_eq("abort/addr", {14'b0, sram_addr}, 32'd0);
        check_eq("abort/freeze_req_pending", {31'b0, freeze}, 32'd1);
        @(negedge clk);
        mem_r_en = 1'b0;
        rst      = 1'b0;
        #1;
        check_eq("abort/ready", {31'b0, ready}, 32'd1);
        check_eq("abort/freeze", {31'b0, freeze}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("abort/rd_data_held", rd_data, 32'd0);
        check_eq("abort/addr_idle", {14'b0, sram_addr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
